// File: rtl/ysyx_25020037_regfile_sb.sv
// rtl/ysyx_25020037_regfile_sb.sv - GPR file with pending-write scoreboard, trap CSRs and counters
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd_addr/rd_data/rd_hazard NRP combinational GPR read ports with hazard flags
//   iss_valid/iss_wen/iss_rd/iss_ready  issue side, bumps the pending counter of iss_rd
//   wb_valid/wb_wen/wb_rd/wb_data       commit side, writes the GPR and retires a pending write
//   csr_addr/csr_rdata/csr_we/csr_wdata CSR access, writes qualified by wb_valid
//   trap_ecall/trap_mret/trap_pc        trap commit, qualified by wb_valid
//   mtvec_o/mepc_o           current trap vector and exception PC
module ysyx_25020037_regfile_sb #(
    parameter int  NREG   = 16,
    parameter int  XLEN   = 32,
    parameter int  NRP    = 2,
    parameter int  PEND_W = 2,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRP*AW-1:0]    rd_addr,
    output logic [NRP*XLEN-1:0]  rd_data,
    output logic [NRP-1:0]       rd_hazard,
    input  logic                 iss_valid,
    input  logic                 iss_wen,
    input  logic [AW-1:0]        iss_rd,
    output logic                 iss_ready,
    input  logic                 wb_valid,
    input  logic                 wb_wen,
    input  logic [AW-1:0]        wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [11:0]          csr_addr,
    output logic [31:0]          csr_rdata,
    input  logic                 csr_we,
    input  logic [31:0]          csr_wdata,
    input  logic                 trap_ecall,
    input  logic                 trap_mret,
    input  logic [31:0]          trap_pc,
    output logic [31:0]          mtvec_o,
    output logic [31:0]          mepc_o
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTR   = 12'hB02;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam logic [11:0] A_MVENDOR  = 12'hF11;
    localparam logic [11:0] A_MARCHID  = 12'hF12;

    logic [XLEN-1:0]   regs_q [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic wb_we;
    logic iss_inc;
    logic csr_wr;

    assign wb_we     = wb_valid & wb_wen & (wb_rd != '0);
    // Saturation check uses the registered count only; a same-cycle retire does not free a slot.
    assign iss_ready = ~(iss_wen & (iss_rd != '0) & (pend_q[iss_rd] == PEND_MAX));
    assign iss_inc   = iss_valid & iss_ready & iss_wen & (iss_rd != '0);
    // Trap commits take precedence; a CSR write riding along with them is dropped.
    assign csr_wr    = wb_valid & csr_we & ~trap_ecall & ~trap_mret;

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          byp;
        assign a   = rd_addr[k*AW +: AW];
        assign byp = (BYPASS != 0) && wb_we && (wb_rd == a);
        assign rd_data[k*XLEN +: XLEN] = (a == '0) ? '0 : (byp ? wb_data : regs_q[a]);
        // A retire landing this cycle resolves the hazard only if it is the last outstanding write.
        assign rd_hazard[k] = (pend_q[a] != '0) && !(byp && (pend_q[a] == PEND_ONE));
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r];
            if (r != 0) begin
                if (iss_inc && (iss_rd == AW'(r)) && !(wb_we && (wb_rd == AW'(r)))) begin
                    pend_d[r] = pend_q[r] + PEND_ONE;
                end else if (wb_we && (wb_rd == AW'(r)) && !(iss_inc && (iss_rd == AW'(r)))
                             && (pend_q[r] != '0)) begin
                    pend_d[r] = pend_q[r] - PEND_ONE;
                end
            end
        end
    end

    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (wb_valid && trap_ecall) begin
            mepc_d    = trap_pc;
            mcause_d  = 32'hB;
            mstatus_d = 32'h1800;
        end else if (wb_valid && trap_mret) begin
            mstatus_d[3]     = mstatus_q[7];
            mstatus_d[7]     = 1'b1;
            mstatus_d[12:11] = 2'b00;
        end else if (csr_wr) begin
            case (csr_addr)
                A_MSTATUS: mstatus_d = csr_wdata;
                A_MTVEC:   mtvec_d   = csr_wdata;
                A_MEPC:    mepc_d    = csr_wdata;
                A_MCAUSE:  mcause_d  = csr_wdata;
                default:   ;
            endcase
        end

        mcycle_d = mcycle_q + 64'd1;
        if (csr_wr && csr_addr == A_MCYCLE)  mcycle_d = {mcycle_q[63:32], csr_wdata};
        if (csr_wr && csr_addr == A_MCYCLEH) mcycle_d = {csr_wdata, mcycle_q[31:0]};

        minstret_d = minstret_q + {63'd0, wb_valid};
        if (csr_wr && csr_addr == A_MINSTR)  minstret_d = {minstret_q[63:32], csr_wdata};
        if (csr_wr && csr_addr == A_MINSTRH) minstret_d = {csr_wdata, minstret_q[31:0]};
    end

    always_comb begin
        case (csr_addr)
            A_MSTATUS: csr_rdata = mstatus_q;
            A_MTVEC:   csr_rdata = mtvec_q;
            A_MEPC:    csr_rdata = mepc_q;
            A_MCAUSE:  csr_rdata = mcause_q;
            A_MCYCLE:  csr_rdata = mcycle_q[31:0];
            A_MCYCLEH: csr_rdata = mcycle_q[63:32];
            A_MINSTR:  csr_rdata = minstret_q[31:0];
            A_MINSTRH: csr_rdata = minstret_q[63:32];
            A_MVENDOR: csr_rdata = 32'h79737978;
            A_MARCHID: csr_rdata = 32'h017DC685;
            default:   csr_rdata = 32'h0;
        endcase
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            mstatus_q  <= 32'h1800;
            mtvec_q    <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            if (wb_we) regs_q[wb_rd] <= wb_data;
            for (int r = 0; r < NREG; r++) pend_q[r] <= pend_d[r];
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_regfile_sb.sv
// tb/tb_ysyx_25020037_regfile_sb.sv - scoreboard bench for ysyx_25020037_regfile_sb
module tb_ysyx_25020037_regfile_sb;

    localparam int NREG   = 16;
    localparam int AW     = 4;
    localparam int XLEN   = 32;
    localparam int NRP    = 2;
    localparam int PEND_W = 2;
    localparam int MAXP   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_hazard;
    logic                iss_valid, iss_wen, iss_ready;
    logic [AW-1:0]       iss_rd;
    logic                wb_valid, wb_wen;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic [11:0]         csr_addr;
    logic [31:0]         csr_rdata, csr_wdata, trap_pc, mtvec_o, mepc_o;
    logic                csr_we, trap_ecall, trap_mret;

    ysyx_25020037_regfile_sb #(
        .NREG(NREG), .XLEN(XLEN), .NRP(NRP), .PEND_W(PEND_W), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_hazard(rd_hazard),
        .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_wdata(csr_wdata),
        .trap_ecall(trap_ecall), .trap_mret(trap_mret), .trap_pc(trap_pc),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o)
    );

    typedef struct {
        logic [NRP*XLEN-1:0] rd;
        logic [NRP-1:0]      hz;
        logic                rdy;
        logic [31:0]         csr;
        logic [31:0]         mtvec;
        logic [31:0]         mepc;
    } exp_t;

    exp_t expq[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    logic [31:0] m_regs [NREG];
    int          m_pend [NREG];
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;

    logic [11:0] csr_list [11] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80,
                                   12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'h123};

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = 0;
            m_pend[r] = 0;
        end
        m_mstatus  = 32'h1800;
        m_mtvec    = 0;
        m_mepc     = 0;
        m_mcause   = 0;
        m_mcycle   = 0;
        m_minstret = 0;
    endtask

    function automatic logic [31:0] m_csr(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
            12'hB02: return m_minstret[31:0];
            12'hB82: return m_minstret[63:32];
            12'hF11: return 32'h79737978;
            12'hF12: return 32'h017DC685;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic rdy);
        bit wbw, inc, csrw;
        logic [63:0] ncyc, nins;
        wbw  = wb_valid && wb_wen && (wb_rd != 0);
        inc  = iss_valid && rdy && iss_wen && (iss_rd != 0);
        csrw = wb_valid && csr_we && !trap_ecall && !trap_mret;
        if (wbw) m_regs[wb_rd] = wb_data;
        if (!(inc && wbw && iss_rd == wb_rd)) begin
            if (inc) m_pend[iss_rd] = m_pend[iss_rd] + 1;
            if (wbw && m_pend[wb_rd] > 0) m_pend[wb_rd] = m_pend[wb_rd] - 1;
        end
        ncyc = m_mcycle + 1;
        nins = m_minstret + (wb_valid ? 1 : 0);
        if (csrw && csr_addr == 12'hB00) ncyc = {m_mcycle[63:32], csr_wdata};
        if (csrw && csr_addr == 12'hB80) ncyc = {csr_wdata, m_mcycle[31:0]};
        if (csrw && csr_addr == 12'hB02) nins = {m_minstret[63:32], csr_wdata};
        if (csrw && csr_addr == 12'hB82) nins = {csr_wdata, m_minstret[31:0]};
        if (wb_valid && trap_ecall) begin
            m_mepc    = trap_pc;
            m_mcause  = 32'hB;
            m_mstatus = 32'h1800;
        end else if (wb_valid && trap_mret) begin
            // MIE takes old MPIE, MPIE set, MPP cleared
            m_mstatus = (m_mstatus & ~32'h1888) | (((m_mstatus >> 7) & 32'h1) << 3) | 32'h80;
        end else if (csrw) begin
            if (csr_addr == 12'h300) m_mstatus = csr_wdata;
            if (csr_addr == 12'h305) m_mtvec   = csr_wdata;
            if (csr_addr == 12'h341) m_mepc    = csr_wdata;
            if (csr_addr == 12'h342) m_mcause  = csr_wdata;
        end
        m_mcycle   = ncyc;
        m_minstret = nins;
    endtask

    task automatic idle();
        rd_addr = '0; iss_valid = 0; iss_wen = 0; iss_rd = '0;
        wb_valid = 0; wb_wen = 0; wb_rd = '0; wb_data = '0;
        csr_addr = '0; csr_we = 0; csr_wdata = '0;
        trap_ecall = 0; trap_mret = 0; trap_pc = '0;
    endtask

    // Called just after a rising edge with inputs set; predicts this cycle's outputs.
    task automatic step();
        exp_t e;
        for (int k = 0; k < NRP; k++) begin
            logic [AW-1:0] a;
            bit byp;
            a   = rd_addr[k*AW +: AW];
            byp = wb_valid && wb_wen && (wb_rd == a) && (a != 0);
            e.rd[k*XLEN +: XLEN] = (a == 0) ? 32'h0 : (byp ? wb_data : m_regs[a]);
            e.hz[k] = (a != 0) && (m_pend[a] != 0) && !(byp && m_pend[a] == 1);
        end
        e.rdy   = !(iss_wen && iss_rd != 0 && m_pend[iss_rd] == MAXP);
        e.csr   = m_csr(csr_addr);
        e.mtvec = m_mtvec;
        e.mepc  = m_mepc;
        expq.push_back(e);
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(e.rdy);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rd_data",   64'(rd_data),   64'(e.rd));
                chk("rd_hazard", 64'(rd_hazard), 64'(e.hz));
                chk("iss_ready", 64'(iss_ready), 64'(e.rdy));
                chk("csr_rdata", 64'(csr_rdata), 64'(e.csr));
                chk("mtvec_o",   64'(mtvec_o),   64'(e.mtvec));
                chk("mepc_o",    64'(mepc_o),    64'(e.mepc));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        idle();
        model_reset();
        rst = 1;
        @(posedge clk); #1;
        step(); step();
        rst = 0;
        step();

        // issue x5, wait, writeback with bypass, then array read
        idle(); rd_addr = 8'h05; iss_valid = 1; iss_wen = 1; iss_rd = 5; step();
        idle(); rd_addr = 8'h05; step(); step();
        idle(); rd_addr = 8'h05; wb_valid = 1; wb_wen = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; step();
        idle(); rd_addr = 8'h50; step();

        // saturate x3
        for (int i = 0; i < 4; i++) begin
            idle(); rd_addr = 8'h03; iss_valid = 1; iss_wen = 1; iss_rd = 3; step();
        end
        idle(); rd_addr = 8'h03; wb_valid = 1; wb_wen = 1; wb_rd = 3; wb_data = 32'h33; step();
        idle(); rd_addr = 8'h03; iss_valid = 1; iss_wen = 1; iss_rd = 3; step();
        idle(); rd_addr = 8'h03; iss_wen = 1; iss_rd = 3; step();
        for (int i = 0; i < 3; i++) begin
            idle(); rd_addr = 8'h03; wb_valid = 1; wb_wen = 1; wb_rd = 3; wb_data = 32'h100 + i; step();
        end

        // same-cycle issue and writeback on x7
        idle(); rd_addr = 8'h07; iss_valid = 1; iss_wen = 1; iss_rd = 7; step();
        idle(); rd_addr = 8'h07; iss_valid = 1; iss_wen = 1; iss_rd = 7;
        wb_valid = 1; wb_wen = 1; wb_rd = 7; wb_data = 32'h77; step();
        idle(); rd_addr = 8'h07; step();
        idle(); rd_addr = 8'h07; wb_valid = 1; wb_wen = 1; wb_rd = 7; wb_data = 32'h78; step();

        // x0 is hardwired
        idle(); rd_addr = 8'h00; wb_valid = 1; wb_wen = 1; wb_rd = 0; wb_data = 32'h1234;
        iss_valid = 1; iss_wen = 1; iss_rd = 0; step();
        idle(); rd_addr = 8'h00; iss_wen = 1; iss_rd = 0; step();

        // ecall with a dropped mtvec write, then mret
        idle(); wb_valid = 1; trap_ecall = 1; trap_pc = 32'h80000010;
        csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h12345678; step();
        idle(); csr_addr = 12'h341; step();
        idle(); csr_addr = 12'h342; step();
        idle(); csr_addr = 12'h305; step();
        idle(); wb_valid = 1; csr_we = 1; csr_addr = 12'h300; csr_wdata = 32'h1880; step();
        idle(); wb_valid = 1; trap_mret = 1; csr_addr = 12'h300; step();
        idle(); csr_addr = 12'h300; step();

        // mcycle low-word wrap
        idle(); wb_valid = 1; csr_we = 1; csr_addr = 12'hB00; csr_wdata = 32'hFFFFFFFF; step();
        idle(); csr_addr = 12'hB00; step();
        idle(); csr_addr = 12'hB80; step();
        idle(); csr_addr = 12'hB02; step();
        idle(); csr_addr = 12'hF11; step();
        idle(); csr_addr = 12'hF12; step();

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst = 1;
                model_reset();
                idle(); step(); step();
                rst = 0;
            end
            idle();
            rd_addr    = NRP*AW'($urandom);
            iss_valid  = ($urandom % 2) == 0;
            iss_wen    = ($urandom % 4) != 0;
            iss_rd     = AW'($urandom % NREG);
            wb_valid   = ($urandom % 2) == 0;
            wb_wen     = ($urandom % 4) != 0;
            wb_rd      = AW'($urandom % NREG);
            wb_data    = $urandom;
            csr_addr   = csr_list[$urandom % 11];
            csr_we     = ($urandom % 4) == 0;
            csr_wdata  = $urandom;
            trap_ecall = ($urandom % 16) == 0;
            trap_mret  = ($urandom % 16) == 0;
            trap_pc    = $urandom;
            step();
        end

        idle();
        @(negedge clk);
        @(negedge clk);
        if (expq.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
